// File: rtl/flag_update_ctrl_if.sv
// Request channel from the micro-op sequencer to the flag update controller.
// The sequencer (master) offers one flag request at a time and holds it until
// the controller (slave) raises req_ready.
interface flag_update_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_class;
    logic [5:0] req_mask;
    logic       req_wide;
    logic       req_ex;
    logic       req_popf;

    modport master (
        output req_valid,
        output req_class,
        output req_mask,
        output req_wide,
        output req_ex,
        output req_popf,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_class,
        input  req_mask,
        input  req_wide,
        input  req_ex,
        input  req_popf,
        output req_ready
    );
endinterface

// File: rtl/flag_update_ctrl.sv
// Flag update controller: accepts one flag request at a time, waits for one or
// two ALU phases, then pulses the per-flag write strobes and the one-hot flag
// source select for a single cycle. EX AF,AF' and POP F requests bypass the ALU
// wait and produce a single swap or load strobe instead.
module flag_update_ctrl (
    input  logic                Clk,
    input  logic                notReset,
    flag_update_ctrl_if.slave   req,
    input  logic                alu_done,
    output logic                PF_Write_S,
    output logic                PF_Write_Z,
    output logic                PF_Write_H,
    output logic                PF_Write_PV,
    output logic                PF_Write_N,
    output logic                PF_Write_C,
    output logic [47:0]         PF_Select,
    output logic                PR_Ex,
    output logic                PR_Write_F,
    output logic                busy,
    output logic                err_class,
    output logic                err_timeout
);

    localparam logic [5:0] NUM_CLASSES = 6'd48;
    // Counter value seen during the 15th consecutive wait cycle without alu_done.
    localparam logic [3:0] WAIT_LAST   = 4'd14;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_LO = 3'd1,
        WAIT_HI = 3'd2,
        COMMIT  = 3'd3,
        SWAP    = 3'd4,
        LOAD    = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] class_q, class_d;
    logic [5:0] mask_q, mask_d;
    logic       wide_q, wide_d;
    logic       err_class_q, err_class_d;
    logic       err_timeout_q, err_timeout_d;

    logic        ready;
    logic [5:0]  pf_write;
    logic [47:0] pf_select;
    logic        class_ok;

    // State, wait counter, request latches and sticky errors; reset wins over everything.
    always_ff @(posedge Clk) begin
        if (!notReset) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            class_q       <= 6'd0;
            mask_q        <= 6'd0;
            wide_q        <= 1'b0;
            err_class_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            class_q       <= class_d;
            mask_q        <= mask_d;
            wide_q        <= wide_d;
            err_class_q   <= err_class_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Next-state logic: request acceptance, ALU phase tracking and wait timeout.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        class_d       = class_q;
        mask_d        = mask_q;
        wide_d        = wide_q;
        err_class_d   = err_class_q;
        err_timeout_d = err_timeout_q;

        case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    class_d = req.req_class;
                    mask_d  = req.req_mask;
                    wide_d  = req.req_wide;
                    // Out-of-range class is still accepted; it just commits nothing.
                    if (req.req_class >= NUM_CLASSES) begin
                        err_class_d = 1'b1;
                    end
                    if (req.req_ex) begin
                        state_d = SWAP;
                    end else if (req.req_popf) begin
                        state_d = LOAD;
                    end else begin
                        state_d = WAIT_LO;
                        cnt_d   = 4'd0;
                    end
                end
            end
            WAIT_LO, WAIT_HI: begin
                if (alu_done) begin
                    cnt_d   = 4'd0;
                    state_d = (state_q == WAIT_LO && wide_q) ? WAIT_HI : COMMIT;
                end else if (cnt_q == WAIT_LAST) begin
                    // ALU never answered: abandon the op without touching F.
                    cnt_d         = 4'd0;
                    state_d       = IDLE;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            COMMIT, SWAP, LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign class_ok = (class_q < NUM_CLASSES);

    // Moore outputs: strobes come purely from the current state and the latched request.
    always_comb begin
        ready      = 1'b0;
        pf_write   = 6'd0;
        pf_select  = 48'd0;
        PR_Ex      = 1'b0;
        PR_Write_F = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
            end
            COMMIT: begin
                if (class_ok) begin
                    pf_write  = mask_q;
                    pf_select = 48'd1 << class_q;
                end
            end
            SWAP: begin
                PR_Ex = 1'b1;
            end
            LOAD: begin
                PR_Write_F = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign req.req_ready = ready;
    assign busy          = ~ready;
    assign PF_Select     = pf_select;
    assign PF_Write_S    = pf_write[5];
    assign PF_Write_Z    = pf_write[4];
    assign PF_Write_H    = pf_write[3];
    assign PF_Write_PV   = pf_write[2];
    assign PF_Write_N    = pf_write[1];
    assign PF_Write_C    = pf_write[0];
    assign err_class     = err_class_q;
    assign err_timeout   = err_timeout_q;

endmodule
